// File: rtl/fpu_op_sequencer.sv
// Single-outstanding issue controller between the FP execute stage and the add/div/mul units.
// Define FPU_SEQ_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYCLES with a qNaN error response.
module fpu_op_sequencer #(
    parameter int TAG_W          = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             add_start,
    output logic             div_start,
    output logic             mul_start,
    output logic [31:0]      unit_a,
    output logic [31:0]      unit_b,
    input  logic             add_done,
    input  logic             div_done,
    input  logic             mul_done,
    input  logic [31:0]      add_result,
    input  logic [31:0]      div_result,
    input  logic [31:0]      mul_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             stall
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    localparam logic [2:0]  OP_ADD = 3'd1;
    localparam logic [2:0]  OP_DIV = 3'd2;
    localparam logic [2:0]  OP_MUL = 3'd3;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [31:0]        result_q, result_d;
    logic               err_q, err_d;
    logic               sel_done;
    logic [31:0]        sel_result;

`ifdef FPU_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            err_q    <= err_d;
`ifdef FPU_SEQ_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Only the unit that was started is listened to; the others may strobe freely.
    always_comb begin
        sel_done   = 1'b0;
        sel_result = '0;
        case (op_q)
            OP_ADD: begin sel_done = add_done; sel_result = add_result; end
            OP_DIV: begin sel_done = div_done; sel_result = div_result; end
            OP_MUL: begin sel_done = mul_done; sel_result = mul_result; end
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every comb output defaults to its held value first, so no path can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        tag_d    = tag_q;
        result_d = result_q;
        err_d    = err_q;
`ifdef FPU_SEQ_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d  = req_op;
                    a_d   = req_a;
                    b_d   = req_b;
                    tag_d = req_tag;
                    if (req_op inside {OP_ADD, OP_DIV, OP_MUL}) begin
                        state_d = S_ISSUE;
                    end else begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef FPU_SEQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (sel_done) begin
                    result_d = sel_result;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
`ifdef FPU_SEQ_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    result_d = QNAN;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        stall     = (state_q != S_IDLE);
        rsp_valid = (state_q == S_RESP);
        add_start = (state_q == S_ISSUE) && (op_q == OP_ADD);
        div_start = (state_q == S_ISSUE) && (op_q == OP_DIV);
        mul_start = (state_q == S_ISSUE) && (op_q == OP_MUL);
    end

    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign rsp_result = result_q;
    assign rsp_tag    = tag_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer: directed plan items plus randomized transactions
// compared against a transaction-level model of expected start, latency and response.
module tb_fpu_op_sequencer;

    localparam int TAG_W = 5;
    localparam int TMO   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready;
    logic [2:0]       req_op;
    logic [31:0]      req_a, req_b;
    logic [TAG_W-1:0] req_tag;
    logic             add_start, div_start, mul_start;
    logic [31:0]      unit_a, unit_b;
    logic             add_done, div_done, mul_done;
    logic [31:0]      add_result, div_result, mul_result;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err, stall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_op_sequencer #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .add_start(add_start), .div_start(div_start), .mul_start(mul_start),
        .unit_a(unit_a), .unit_b(unit_b),
        .add_done(add_done), .div_done(div_done), .mul_done(mul_done),
        .add_result(add_result), .div_result(div_result), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .stall(stall)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dones();
        add_done = 1'b0;
        div_done = 1'b0;
        mul_done = 1'b0;
    endtask

    task automatic drive_done(input int unit, input logic [31:0] res);
        case (unit)
            1: begin add_done = 1'b1; add_result = res; end
            2: begin div_done = 1'b1; div_result = res; end
            3: begin mul_done = 1'b1; mul_result = res; end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] starts();
        return {29'b0, add_start, div_start, mul_start};
    endfunction

    task automatic check_reset_outputs(input string where);
        check({where, "_req_ready"},  32'(req_ready),  32'd1);
        check({where, "_stall"},      32'(stall),      32'd0);
        check({where, "_rsp_valid"},  32'(rsp_valid),  32'd0);
        check({where, "_starts"},     starts(),        32'd0);
        check({where, "_unit_a"},     unit_a,          32'd0);
        check({where, "_unit_b"},     unit_b,          32'd0);
        check({where, "_rsp_result"}, rsp_result,      32'd0);
        check({where, "_rsp_tag"},    32'(rsp_tag),    32'd0);
        check({where, "_rsp_err"},    32'(rsp_err),    32'd0);
    endtask

    // Transaction model: lat = cycles after the start pulse at which the unit strobes done
    // (0 = never, only meaningful with the timeout feature). rdly = cycles rsp_ready held low.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input int lat, input int rdly,
                         input bit junk, input logic [31:0] res);
        bit          legal;
        int          n_wait;
        logic [31:0] exp_start, exp_res, exp_err;
        legal     = (op >= 3'd1) && (op <= 3'd3);
        n_wait    = (lat == 0) ? TMO : lat;
        exp_start = legal ? (32'd8 >> op) : 32'd0;
        exp_res   = !legal ? 32'd0 : ((lat == 0) ? 32'h7FC0_0000 : res);
        exp_err   = (!legal || lat == 0) ? 32'd1 : 32'd0;

        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_stall", 32'(stall), 32'd0);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        tick();
        req_valid = 1'b0; req_op = 3'd0; req_a = ~a; req_b = ~b; req_tag = ~tag;
        check("accept_stall", 32'(stall), 32'd1);
        check("accept_ready", 32'(req_ready), 32'd0);
        check("start_pulse", starts(), exp_start);
        if (legal) begin
            check("unit_a", unit_a, a);
            check("unit_b", unit_b, b);
            check("issue_rsp_valid", 32'(rsp_valid), 32'd0);
            for (int i = 1; i <= n_wait; i++) begin
                tick();
                clear_dones();
                check("wait_starts", starts(), 32'd0);
                check("wait_rsp_valid", 32'(rsp_valid), 32'd0);
                check("wait_unit_a", unit_a, a);
                if (i == lat) begin
                    drive_done(int'(op), res);
                end else if (junk) begin
                    for (int u = 1; u <= 3; u++)
                        if (u != int'(op)) drive_done(u, $urandom);
                end
            end
            tick();
            clear_dones();
        end
        for (int r = 0; r <= rdly; r++) begin
            if (r > 0) tick();
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_result", rsp_result, exp_res);
            check("rsp_tag", 32'(rsp_tag), 32'(tag));
            check("rsp_err", 32'(rsp_err), exp_err);
            check("rsp_req_ready", 32'(req_ready), 32'd0);
            check("rsp_stall", 32'(stall), 32'd1);
        end
        // A request offered during the handshake cycle must not be taken.
        rsp_ready = 1'b1; req_valid = 1'b1; req_op = 3'd1;
        tick();
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_stall", 32'(stall), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0; req_op = 3'd0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        rsp_ready = 1'b0; clear_dones();
        add_result = '0; div_result = '0; mul_result = '0;
        tick(); tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        do_op(3'd1, 32'h3F80_0000, 32'h4000_0000, 5'd5, 2, 0, 1'b0, 32'h4040_0000);
`ifdef FPU_SEQ_TIMEOUT_EN
        do_op(3'd2, 32'h3F80_0000, 32'h4000_0000, 5'd6, TMO, 4, 1'b0, 32'h3F00_0000);
        do_op(3'd1, 32'h3F80_0000, 32'h3F80_0000, 5'd7, 0, 0, 1'b0, 32'h0);
`else
        do_op(3'd2, 32'h3F80_0000, 32'h4000_0000, 5'd6, 10, 4, 1'b0, 32'h3F00_0000);
        do_op(3'd1, 32'h4120_0000, 32'h4120_0000, 5'd7, 40, 1, 1'b1, 32'h41A0_0000);
`endif
        do_op(3'd3, 32'h4000_0000, 32'h40A0_0000, 5'd3, 4, 0, 1'b1, 32'h4120_0000);
        do_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, 1, 0, 1'b0, 32'hDEAD_BEEF);
        do_op(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, 1, 2, 1'b0, 32'hDEAD_BEEF);

        // Reset while the divider is in flight; its late done must be ignored.
        req_valid = 1'b1; req_op = 3'd2; req_a = 32'h4080_0000; req_b = 32'h4000_0000; req_tag = 5'd12;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midop_reset");
        tick(); tick();
        drive_done(2, 32'h4000_0000);
        tick();
        clear_dones();
        check("late_done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("late_done_stall", 32'(stall), 32'd0);
        tick();
        check("late_done_rsp_valid2", 32'(rsp_valid), 32'd0);
        check("late_done_ready", 32'(req_ready), 32'd1);

        for (int n = 0; n < 16; n++) begin
            do_op(3'($urandom_range(0, 7)), $urandom, $urandom, TAG_W'($urandom),
                  $urandom_range(1, TMO), $urandom_range(0, 3), 1'($urandom), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
